// File: rtl/lbp_pkg.sv
// Shared constants and state encoding for the LBP histogram block.
package lbp_pkg;

    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int ADDR_W = $clog2(IMG_W * IMG_H);
    localparam int NBINS  = 256;
    localparam int BIN_W  = $clog2(NBINS);

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        DUMP,
        DONE
    } state_e;

endpackage

// File: rtl/lbp_hist_if.sv
// Histogram dump stream: one bin/count word per valid/ready handshake.
interface lbp_hist_if
    import lbp_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic             hist_valid;
    logic             hist_ready;
    logic [BIN_W-1:0] hist_bin;
    logic [CNT_W-1:0] hist_count;

    modport master (
        output hist_valid,
        output hist_bin,
        output hist_count,
        input  hist_ready
    );

    modport slave (
        input  hist_valid,
        input  hist_bin,
        input  hist_count,
        output hist_ready
    );

endinterface

// File: rtl/lbp_hist_ram.sv
// Bin count storage: one synchronous read port, one write port, old data on collision.
module lbp_hist_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; the top keeps per-bin valid flags instead,
    // so a never-written entry is masked to zero rather than cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/lbp_hist.sv
// Accumulates a 256-bin histogram of LBP codes for one frame, then streams
// the bins out over a valid/ready port.
module lbp_hist
    import lbp_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int NPIX_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [BIN_W-1:0]  lbp_data,
    input  logic              finish,
    output logic [NPIX_W-1:0] npix,
    output logic              busy,
    output logic              hist_done,
    lbp_hist_if.master        hist
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  last_addr;
    logic [NPIX_W-1:0]  npix_q;
    logic               accept;
    logic               handshake;

    logic [BIN_W-1:0]   rd_addr;
    logic [BIN_W-1:0]   rd_bin_q;
    logic [CNT_W-1:0]   rdata;
    logic [CNT_W-1:0]   rd_val;
    logic [CNT_W-1:0]   cur_val;
    logic [CNT_W-1:0]   wr_data;
    logic               s1_valid;
    logic               byp_valid;
    logic [CNT_W-1:0]   byp_data;
    logic [NBINS-1:0]   bin_flag;

    logic               valid_q;
    logic [BIN_W-1:0]   bin_q;
    logic [CNT_W-1:0]   count_q;

    lbp_hist_ram #(
        .W     (CNT_W),
        .DEPTH (NBINS),
        .AW    (BIN_W)
    ) u_ram (
        .clk   (clk),
        .raddr (rd_addr),
        .rdata (rdata),
        .we    (s1_valid),
        .waddr (rd_bin_q),
        .wdata (wr_data)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        rd_addr   = lbp_data;
        handshake = valid_q && hist.hist_ready;
        case (state_q)
            ACCUM: begin
                accept = lbp_valid && (lbp_addr != last_addr);
                if (finish) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                rd_addr = '0;
                if (!s1_valid) begin
                    state_d = DUMP;
                end
            end
            DUMP: begin
                // The RAM always looks one bin ahead of the presented word.
                if (!valid_q) begin
                    rd_addr = BIN_W'(1);
                end else if (handshake) begin
                    rd_addr = bin_q + BIN_W'(2);
                    if (bin_q == BIN_W'(NBINS - 1)) begin
                        state_d = DONE;
                    end
                end else begin
                    rd_addr = bin_q + BIN_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Unwritten bins read as zero; a write landing on the bin being read
    // in the same cycle is forwarded because the RAM returns old data.
    assign rd_val  = bin_flag[rd_bin_q] ? rdata : '0;
    assign cur_val = byp_valid ? byp_data : rd_val;
    assign wr_data = (cur_val == '1) ? cur_val : cur_val + CNT_W'(1);

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ACCUM;
            last_addr <= '1;
            npix_q    <= '0;
            s1_valid  <= 1'b0;
            rd_bin_q  <= '0;
            byp_valid <= 1'b0;
            byp_data  <= '0;
            bin_flag  <= '0;
        end else begin
            state_q   <= state_d;
            s1_valid  <= accept;
            rd_bin_q  <= rd_addr;
            byp_valid <= accept && s1_valid && (rd_bin_q == rd_addr);
            byp_data  <= wr_data;
            if (s1_valid) begin
                bin_flag[rd_bin_q] <= 1'b1;
            end
            if (accept) begin
                last_addr <= lbp_addr;
                if (npix_q != '1) begin
                    npix_q <= npix_q + NPIX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            bin_q   <= '0;
            count_q <= '0;
        end else if (state_q == DUMP) begin
            if (!valid_q) begin
                valid_q <= 1'b1;
                bin_q   <= '0;
                count_q <= rd_val;
            end else if (handshake) begin
                if (bin_q == BIN_W'(NBINS - 1)) begin
                    valid_q <= 1'b0;
                end else begin
                    bin_q   <= bin_q + BIN_W'(1);
                    count_q <= rd_val;
                end
            end
        end
    end

    assign hist.hist_valid = valid_q;
    assign hist.hist_bin   = bin_q;
    assign hist.hist_count = count_q;
    assign npix            = npix_q;
    assign busy            = (state_q != DONE);
    assign hist_done       = (state_q == DONE);

endmodule

// File: tb/tb_lbp_hist.sv
// Randomised scoreboard bench for lbp_hist against a plain-array histogram model.
module tb_lbp_hist;
    import lbp_pkg::*;

    localparam int CNT_W  = 16;
    localparam int NPIX_W = 15;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int NPIX_MAX = (1 << NPIX_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              lbp_valid = 1'b0;
    logic [ADDR_W-1:0] lbp_addr = '0;
    logic [BIN_W-1:0]  lbp_data = '0;
    logic              finish = 1'b0;
    logic [NPIX_W-1:0] npix;
    logic              busy;
    logic              hist_done;

    lbp_hist_if #(.CNT_W(CNT_W)) hist ();

    lbp_hist #(
        .CNT_W  (CNT_W),
        .NPIX_W (NPIX_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .lbp_valid (lbp_valid),
        .lbp_addr  (lbp_addr),
        .lbp_data  (lbp_data),
        .finish    (finish),
        .npix      (npix),
        .busy      (busy),
        .hist_done (hist_done),
        .hist      (hist)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bin;
        int count;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   model_hist[NBINS];
    int   model_npix;
    int   model_last;
    int   rx_sum;

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: pops one expected word per observed handshake.
    initial begin
        bit             stalled_prev;
        logic [7:0]     bin_prev;
        logic [CNT_W-1:0] cnt_prev;
        exp_t           e;
        stalled_prev = 1'b0;
        bin_prev = '0;
        cnt_prev = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled_prev = 1'b0;
            end else begin
                if (stalled_prev) begin
                    check("stall_valid", hist.hist_valid, 1);
                    check("stall_bin", hist.hist_bin, bin_prev);
                    check("stall_count", hist.hist_count, cnt_prev);
                end
                if (hist.hist_valid && hist.hist_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("dump_bin", hist.hist_bin, e.bin);
                        check("dump_count", hist.hist_count, e.count);
                    end
                    rx_sum += int'(hist.hist_count);
                end
                stalled_prev = hist.hist_valid && !hist.hist_ready;
                bin_prev = hist.hist_bin;
                cnt_prev = hist.hist_count;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic model_clear();
        for (int b = 0; b < NBINS; b++) model_hist[b] = 0;
        model_npix = 0;
        model_last = 'h3FFF;
        rx_sum = 0;
    endtask

    // One ACCUM cycle; the model applies the accept rule directly.
    task automatic pix(input bit v, input int addr, input int data);
        lbp_valid = v;
        lbp_addr  = ADDR_W'(addr);
        lbp_data  = BIN_W'(data);
        if (v && addr != model_last) begin
            model_last = addr;
            if (model_hist[data] < CNT_MAX) model_hist[data]++;
            if (model_npix < NPIX_MAX) model_npix++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        lbp_valid = 1'b0;
        finish = 1'b0;
        hist.hist_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_hist_valid", hist.hist_valid, 0);
        check("rst_hist_done", hist_done, 0);
        check("rst_hist_bin", hist.hist_bin, 0);
        check("rst_hist_count", hist.hist_count, 0);
        check("rst_npix", npix, 0);
        check("rst_busy", busy, 1);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic push_expected();
        exp_t e;
        for (int b = 0; b < NBINS; b++) begin
            e.bin = b;
            e.count = model_hist[b];
            exp_q.push_back(e);
        end
    endtask

    // mode 0: ready high, 1: ready pattern 1,0,0, 2: random ready
    task automatic dump(input int mode);
        int cyc;
        int bubbles;
        int k;
        bit seen;
        push_expected();
        rx_sum = 0;
        lbp_valid = 1'b0;
        finish = 1'b1;
        cyc = 0;
        bubbles = 0;
        k = 0;
        seen = 1'b0;
        while (!hist_done && cyc < 4000) begin
            case (mode)
                0: hist.hist_ready = 1'b1;
                1: hist.hist_ready = (k % 3 == 0);
                default: hist.hist_ready = 1'($urandom_range(0, 1));
            endcase
            k++;
            @(negedge clk);
            if (seen && !hist.hist_valid && !hist_done) bubbles++;
            if (hist.hist_valid) seen = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        hist.hist_ready = 1'b0;
        check("hist_done", hist_done, 1);
        check("busy_after_dump", busy, 0);
        check("valid_after_dump", hist.hist_valid, 0);
        check("words_left", exp_q.size(), 0);
        check("npix", npix, model_npix);
        check("count_sum", rx_sum, model_npix);
        if (mode == 0) check("bubbles_le_1", bubbles <= 1, 1);
    endtask

    initial begin
        int frame_pix;
        int hold;
        int found;
        int cyc;
        frame_pix = (IMG_W - 2) * (IMG_H - 2);

        // Single pixel
        do_reset();
        pix(1, 129, 'h5A);
        dump(0);

        // Terminal state ignores further traffic
        lbp_valid = 1'b1;
        lbp_addr  = ADDR_W'(777);
        lbp_data  = 8'd1;
        repeat (3) @(posedge clk);
        #1;
        lbp_valid = 1'b0;
        check("done_npix_frozen", npix, model_npix);
        check("done_sticky", hist_done, 1);
        check("done_no_valid", hist.hist_valid, 0);

        // Held valid, same-bin increments and bypass hazards, backpressure dump
        do_reset();
        repeat (10) pix(1, 200, 3);
        check("held_npix", npix, model_npix);
        pix(1, 201, 3);
        for (int a = 300; a < 304; a++) pix(1, a, 'hFF);
        pix(1, 304, 7);
        pix(1, 305, 8);
        pix(1, 306, 7);
        pix(1, 307, 8);
        pix(0, 0, 0);
        dump(1);

        // Full frame with random holds and gaps, random ready
        do_reset();
        for (int y = 1; y < IMG_H - 1; y++) begin
            for (int x = 1; x < IMG_W - 1; x++) begin
                hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
                pix(1, y * IMG_W + x, (x + y) & 'hFF);
                repeat (hold) pix(1, y * IMG_W + x, (x + y) & 'hFF);
                if ($urandom_range(0, 9) == 0) pix(0, 0, 0);
            end
        end
        check("frame_npix", npix, frame_pix);
        dump(2);

        // Random stream, reset in the middle of the dump
        do_reset();
        for (int i = 0; i < 400; i++) begin
            pix($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255)));
        end
        push_expected();
        lbp_valid = 1'b0;
        finish = 1'b1;
        hist.hist_ready = 1'b1;
        found = 0;
        cyc = 0;
        while (found == 0 && cyc < 2000) begin
            @(negedge clk);
            if (hist.hist_valid && hist.hist_bin == 8'd100) found = 1;
            else cyc++;
        end
        check("reached_bin_100", found, 1);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_hist_valid", hist.hist_valid, 0);
        check("midrst_npix", npix, 0);
        check("midrst_hist_done", hist_done, 0);
        do_reset();
        pix(1, 4000, 9);
        dump(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
